// File: rtl/flop_array_rw_pkg.sv
// -----------------------------------------------------------------------------
// flop_array_rw_pkg
// Purpose : small helpers used by the flop_array_rw storage block.
//           padded_entries() turns an address width into the number of
//           addressable slots, so the array can be sized as a power of two
//           even when the real DEPTH is not.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package flop_array_rw_pkg;

  // Number of slots reachable with an address of the given width.
  function automatic int padded_entries(input int bitdep);
    return 1 << bitdep;
  endfunction

endpackage : flop_array_rw_pkg

// File: rtl/flop_array_rw_muxn_noglitch.sv
// -----------------------------------------------------------------------------
// muxn_noglitch
// Purpose : N:1 read mux built as a decoded AND-OR tree. Each data input is
//           gated by its own decode term and the terms are ORed, so the
//           output depends on the select only through a single gating
//           level per input. There is no priority chain, so an unchanged
//           select never produces a transient on the output.
// Ports   :
//   sel   in  SELW         select, expected straight from a flop
//   din   in  WIDTH x PRT  data inputs (unpacked array)
//   dout  out WIDTH        selected data
// -----------------------------------------------------------------------------
module muxn_noglitch #(
  parameter  int WIDTH = 32,
  parameter  int PRT   = 32,
  localparam int SELW  = (PRT > 1) ? $clog2(PRT) : 1
) (
  input  logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] din [PRT],
  output logic [WIDTH-1:0] dout
);

  logic [PRT-1:0] hit;

  // One-hot decode of the select.
  always_comb begin
    hit = '0;
    for (int i = 0; i < PRT; i++) begin
      hit[i] = (sel == SELW'(i));
    end
  end

  // Gate every input with its decode bit and OR everything together.
  always_comb begin
    dout = '0;
    for (int i = 0; i < PRT; i++) begin
      dout = dout | (din[i] & {WIDTH{hit[i]}});
    end
  end

endmodule : muxn_noglitch

// File: rtl/flop_array_rw.sv
// -----------------------------------------------------------------------------
// flop_array_rw
// Purpose : flop-based register array with one write port and a two-stage
//           read pipeline. The read address is captured in rd_sel_q, which
//           feeds muxn_noglitch directly so the mux select only moves on an
//           accepted read. The mux output is registered into dout.
// Build option : FLOP_ARRAY_BYPASS_EN
//   defined   - a write that hits the entry being read out this cycle is
//               forwarded into dout (newest data).
//   undefined - dout takes the mux value as it was before the write.
// Ports :
//   clk     in   1       clock, all state on rising edge
//   rst     in   1       synchronous active-high reset
//   write   in   1       write strobe
//   wr_adr  in   BITDEP  write address (>= DEPTH is dropped)
//   din     in   WIDTH   write data
//   read    in   1       read strobe
//   rd_adr  in   BITDEP  read address (>= DEPTH reads as 0)
//   rd_vld  out  1       dout holds data for the read issued two cycles ago
//   dout    out  WIDTH   registered read data
// -----------------------------------------------------------------------------
module flop_array_rw
  import flop_array_rw_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int BITDEP = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [BITDEP-1:0] wr_adr,
  input  logic [WIDTH-1:0]  din,
  input  logic              read,
  input  logic [BITDEP-1:0] rd_adr,
  output logic              rd_vld,
  output logic [WIDTH-1:0]  dout
);

  localparam int PADDED = padded_entries(BITDEP);
  localparam logic [BITDEP:0] DEPTH_W = DEPTH[BITDEP:0];

  logic [WIDTH-1:0]  mem_q [PADDED];
  logic [WIDTH-1:0]  mem_d [PADDED];
  logic [BITDEP-1:0] rd_sel_q, rd_sel_d;
  logic              rd_p1_q, rd_p1_d;
  logic              rd_vld_q, rd_vld_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WIDTH-1:0]  mux_out;
  logic              wr_ok;

  assign wr_ok = write && ({1'b0, wr_adr} < DEPTH_W);

  // Storage next state: slots past DEPTH stay constant zero, so they read
  // back as 0 and synthesis can drop their flops.
  always_comb begin
    for (int i = 0; i < PADDED; i++) begin
      mem_d[i] = (i < DEPTH) ? mem_q[i] : '0;
    end
    if (wr_ok) begin
      mem_d[wr_adr] = din;
    end
  end

  // Read control: the select only moves on an accepted read, the stage-1
  // valid just follows the strobe.
  always_comb begin
    rd_sel_d = read ? rd_adr : rd_sel_q;
    rd_p1_d  = read;
  end

  // Output stage. With forwarding, a write landing on the entry whose mux
  // value is being captured wins over the stale mux output.
  always_comb begin
    dout_d   = dout_q;
    rd_vld_d = rd_p1_q;
    if (rd_p1_q) begin
`ifdef FLOP_ARRAY_BYPASS_EN
      dout_d = (wr_ok && (wr_adr == rd_sel_q)) ? din : mux_out;
`else
      dout_d = mux_out;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PADDED; i++) begin
        mem_q[i] <= '0;
      end
      rd_sel_q <= '0;
      rd_p1_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      for (int i = 0; i < PADDED; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_sel_q <= rd_sel_d;
      rd_p1_q  <= rd_p1_d;
      rd_vld_q <= rd_vld_d;
      dout_q   <= dout_d;
    end
  end

  muxn_noglitch #(
    .WIDTH (WIDTH),
    .PRT   (PADDED)
  ) u_mux (
    .sel  (rd_sel_q),
    .din  (mem_q),
    .dout (mux_out)
  );

  assign rd_vld = rd_vld_q;
  assign dout   = dout_q;

endmodule : flop_array_rw

// File: tb/tb_flop_array_rw.sv
// -----------------------------------------------------------------------------
// tb_flop_array_rw
// Purpose : directed bench for flop_array_rw. Two instances share the same
//           stimulus: dut32 (DEPTH=32) and dut20 (DEPTH=20, same 5-bit
//           address), so out-of-range behaviour is exercised alongside the
//           full-size array. Expected values are written out by hand.
// Build option : FLOP_ARRAY_BYPASS_EN selects the expected collision result.
// -----------------------------------------------------------------------------
module tb_flop_array_rw;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [4:0]  wrAdr;
  logic [31:0] din;
  logic        read;
  logic [4:0]  rdAdr;
  logic        rdVld32, rdVld20;
  logic [31:0] dout32, dout20;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  flop_array_rw #(.WIDTH(32), .DEPTH(32)) dut32 (
    .clk    (clk),
    .rst    (rst),
    .write  (write),
    .wr_adr (wrAdr),
    .din    (din),
    .read   (read),
    .rd_adr (rdAdr),
    .rd_vld (rdVld32),
    .dout   (dout32)
  );

  flop_array_rw #(.WIDTH(32), .DEPTH(20)) dut20 (
    .clk    (clk),
    .rst    (rst),
    .write  (write),
    .wr_adr (wrAdr),
    .din    (din),
    .read   (read),
    .rd_adr (rdAdr),
    .rd_vld (rdVld20),
    .dout   (dout20)
  );

  // Drive one cycle of inputs, then advance past the next rising edge so the
  // outputs seen afterwards belong to that edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wa,
                               input logic [31:0] d, input logic rd, input logic [4:0] ra);
    rst   = r;
    write = w;
    wrAdr = wa;
    din   = d;
    read  = rd;
    rdAdr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  // Check both instances at once.
  task automatic checkBoth(input string tag, input logic v32, input logic [31:0] d32,
                           input logic v20, input logic [31:0] d20);
    checkOutput({tag, "_vld32"}, {31'b0, rdVld32}, {31'b0, v32});
    checkOutput({tag, "_dout32"}, dout32, d32);
    checkOutput({tag, "_vld20"}, {31'b0, rdVld20}, {31'b0, v20});
    checkOutput({tag, "_dout20"}, dout20, d20);
  endtask

  initial begin
    logic [31:0] collisionExp;
`ifdef FLOP_ARRAY_BYPASS_EN
    collisionExp = 32'h0000_0022;
`else
    collisionExp = 32'h0000_0011;
`endif

    // Reset for one edge.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkBoth("reset", 1'b0, 32'h0, 1'b0, 32'h0);

    // Read address 5 after reset: valid two edges later, data 0.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    checkBoth("rd5_e0", 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    checkBoth("rd5_e1", 1'b1, 32'h0, 1'b1, 32'h0);
    idle();
    checkBoth("rd5_done", 1'b0, 32'h0, 1'b0, 32'h0);

    // Write 3, read it back the next cycle.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    idle();
    checkBoth("wr3_rd3", 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);

    // Same-cycle write and read of 3 returns the new data.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 5'd3);
    idle();
    checkBoth("same_cyc", 1'b1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);

    // Collision: read 7 at E0, write 7 at E1.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
    checkBoth("collide", 1'b1, collisionExp, 1'b1, collisionExp);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    idle();
    checkBoth("collide_after", 1'b1, 32'h22, 1'b1, 32'h22);

    // Streaming: fill every slot, then read them all back-to-back.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 1'b0, 5'd0);
    end
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i));
      else        idle();
      if (i > 0) begin
        checkBoth($sformatf("stream%0d", i - 1), 1'b1, 32'(i - 1) * 32'h0101_0101,
                  1'b1, (i - 1 < 20) ? 32'(i - 1) * 32'h0101_0101 : 32'h0);
      end
    end
    // Idle: output holds and valid drops, for several cycles.
    for (int i = 0; i < 3; i++) begin
      idle();
      checkBoth($sformatf("hold%0d", i), 1'b0, 32'h1F1F_1F1F, 1'b0, 32'h0);
    end

    // Reads with a bubble between them.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    idle();
    checkBoth("bub4", 1'b1, 32'h0404_0404, 1'b1, 32'h0404_0404);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    checkBoth("bub_gap", 1'b0, 32'h0404_0404, 1'b0, 32'h0404_0404);
    idle();
    checkBoth("bub9", 1'b1, 32'h0909_0909, 1'b1, 32'h0909_0909);

    // Out-of-range for the DEPTH=20 instance: write 25 dropped, reads 0.
    applyStimulus(1'b0, 1'b1, 5'd25, 32'hAAAA_5555, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd19, 32'h0000_1234, 1'b1, 5'd25);
    checkBoth("oor_e0", 1'b0, 32'h0909_0909, 1'b0, 32'h0909_0909);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd19);
    checkBoth("oor25", 1'b1, 32'hAAAA_5555, 1'b1, 32'h0);
    idle();
    checkBoth("rd19", 1'b1, 32'h0000_1234, 1'b1, 32'h0000_1234);

    // Mid-flight reset, with read asserted during reset.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    checkBoth("mrst_e1", 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    checkBoth("mrst_e2", 1'b0, 32'h0, 1'b0, 32'h0);

    // Memory was cleared by reset.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    idle();
    checkBoth("cleared3", 1'b1, 32'h0, 1'b1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule : tb_flop_array_rw
